// File: rtl/demux1_8_chan.sv
// demux1_8_chan: registered 1-to-8 channel router with per-channel valid/ready holding registers
module demux1_8_chan #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_sel,
  input  logic               in_bcast,
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ready,
  output logic [8*WIDTH-1:0] out_data,
  output logic [15:0]        accept_cnt
);
  logic [7:0] free, load;
  logic       take;
  // a channel draining this cycle can be refilled at the same edge
  assign free     = ~out_valid | out_ready;
  assign in_ready = reset_n & (in_bcast ? &free : free[in_sel]);
  assign take     = in_valid & in_ready;
  assign load     = take ? (in_bcast ? 8'hFF : 8'(1) << in_sel) : 8'h00;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid  <= '0;
      out_data   <= '0;
      accept_cnt <= '0;
    end else begin
      out_valid <= load | (out_valid & ~out_ready);
      for (int k = 0; k < 8; k++)
        if (load[k]) out_data[k*WIDTH +: WIDTH] <= in_data;
      if (take) accept_cnt <= accept_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_demux1_8_chan.sv
// tb_demux1_8_chan: directed self-checking bench for demux1_8_chan
module tb_demux1_8_chan;
  logic         clk = 0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic [2:0]   in_sel;
  logic         in_bcast;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [511:0] out_data;
  logic [15:0]  accept_cnt;
  int pass_cnt = 0;
  int total = 0;
  logic [15:0] exp_cnt;

  demux1_8_chan #(.WIDTH(64)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .accept_cnt(accept_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] slice(input int k);
    return out_data[k*64 +: 64];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 0; in_valid = 1; in_sel = 0; in_bcast = 0; in_data = 64'h1234; out_ready = 0;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    tick();
    total++; if (out_valid !== 8'h00) $display("FAIL reset_out_valid got=%h exp=00", out_valid); else pass_cnt++;
    total++; if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", out_data); else pass_cnt++;
    total++; if (accept_cnt !== 16'h0) $display("FAIL reset_cnt got=%h exp=0", accept_cnt); else pass_cnt++;
    exp_cnt = 0;
  endtask

  task automatic test_unicast();
    @(negedge clk);
    reset_n = 1; in_valid = 1; in_sel = 3; in_bcast = 0; in_data = 64'hDEAD_BEEF; out_ready = 0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL uni_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    tick(); exp_cnt++;
    total++; if (out_valid !== 8'h08) $display("FAIL uni_out_valid got=%h exp=08", out_valid); else pass_cnt++;
    total++; if (slice(3) !== 64'hDEAD_BEEF) $display("FAIL uni_data got=%h exp=deadbeef", slice(3)); else pass_cnt++;
    total++; if (accept_cnt !== 16'd1) $display("FAIL uni_cnt got=%0d exp=1", accept_cnt); else pass_cnt++;
    total++; if (in_ready !== 1'b0) $display("FAIL uni_blocked got=%b exp=0", in_ready); else pass_cnt++;
    @(negedge clk);
    in_data = 64'h5555;
    tick();
    total++; if (slice(3) !== 64'hDEAD_BEEF || accept_cnt !== exp_cnt)
      $display("FAIL uni_hold data=%h cnt=%0d exp=deadbeef/%0d", slice(3), accept_cnt, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_drain_refill();
    @(negedge clk);
    in_valid = 1; in_sel = 5; in_data = 64'h1; out_ready = 0;
    tick(); exp_cnt++;
    @(negedge clk);
    out_ready = 8'h20; in_data = 64'h2;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL refill_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    tick(); exp_cnt++;
    total++; if (out_valid !== 8'h28 || slice(5) !== 64'h2)
      $display("FAIL refill got valid=%h data=%h exp=28/2", out_valid, slice(5)); else pass_cnt++;
    total++; if (accept_cnt !== exp_cnt) $display("FAIL refill_cnt got=%0d exp=%0d", accept_cnt, exp_cnt); else pass_cnt++;
    @(negedge clk);
    in_valid = 0; out_ready = 8'h28;
    tick();
    total++; if (out_valid !== 8'h00 || slice(5) !== 64'h2 || slice(3) !== 64'hDEAD_BEEF)
      $display("FAIL drain_persist got valid=%h s5=%h s3=%h exp=00/2/deadbeef", out_valid, slice(5), slice(3)); else pass_cnt++;
    @(negedge clk);
    out_ready = 8'hFF;
    tick();
    total++; if (out_valid !== 8'h00) $display("FAIL ready_when_empty got=%h exp=00", out_valid); else pass_cnt++;
  endtask

  task automatic test_bcast();
    @(negedge clk);
    in_valid = 1; in_sel = 6; in_bcast = 0; in_data = 64'h6; out_ready = 0;
    tick(); exp_cnt++;
    @(negedge clk);
    in_bcast = 1; in_sel = 0; in_data = 64'hA5A5_5A5A_0F0F_F0F0;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL bcast_blocked got=%b exp=0", in_ready); else pass_cnt++;
    out_ready = 8'h40;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL bcast_ready got=%b exp=1", in_ready); else pass_cnt++;
    tick(); exp_cnt++;
    total++; if (out_valid !== 8'hFF) $display("FAIL bcast_valid got=%h exp=ff", out_valid); else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      total++; if (slice(k) !== 64'hA5A5_5A5A_0F0F_F0F0)
        $display("FAIL bcast_data ch%0d got=%h exp=a5a55a5a0f0ff0f0", k, slice(k)); else pass_cnt++;
    end
    total++; if (accept_cnt !== exp_cnt) $display("FAIL bcast_cnt got=%0d exp=%0d", accept_cnt, exp_cnt); else pass_cnt++;
    @(negedge clk);
    in_valid = 0; in_bcast = 0; out_ready = 8'hFF;
    tick();
    total++; if (out_valid !== 8'h00) $display("FAIL bcast_drain got=%h exp=00", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] tbl [8] = '{64'd64357, 64'd26000, 64'd24556, 64'd12328, 64'd63, 64'd31, 64'd132346, 64'd7};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1; in_bcast = 0; in_sel = 3'(i); in_data = tbl[i]; out_ready = 8'hFF;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL stream_ready%0d got=%b exp=1", i, in_ready); else pass_cnt++;
      tick(); exp_cnt++;
      total++; if (out_valid !== 8'(1 << i) || slice(i) !== tbl[i])
        $display("FAIL stream%0d got valid=%h data=%0d exp=%h/%0d", i, out_valid, slice(i), 8'(1 << i), tbl[i]); else pass_cnt++;
    end
    total++; if (accept_cnt !== exp_cnt) $display("FAIL stream_cnt got=%0d exp=%0d", accept_cnt, exp_cnt); else pass_cnt++;
    @(negedge clk);
    in_valid = 0;
    tick();
  endtask

  task automatic test_mid_reset();
    logic [2:0] chans [4] = '{3'd1, 3'd3, 3'd4, 3'd6};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1; in_sel = chans[i]; in_data = 64'h100 + 64'(i); out_ready = 0;
      tick();
    end
    total++; if (out_valid !== 8'h5A) $display("FAIL mid_setup got=%h exp=5a", out_valid); else pass_cnt++;
    @(negedge clk);
    reset_n = 0; in_sel = 0;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL mid_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    tick();
    total++; if (out_valid !== 8'h00 || out_data !== '0 || accept_cnt !== 16'h0)
      $display("FAIL mid_reset got valid=%h cnt=%0d data_nonzero=%b exp=00/0/0", out_valid, accept_cnt, |out_data); else pass_cnt++;
    @(negedge clk);
    reset_n = 1; in_valid = 0;
    tick();
    total++; if (out_valid !== 8'h00) $display("FAIL post_reset_valid got=%h exp=00", out_valid); else pass_cnt++;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    in_valid = 1; in_bcast = 0; in_sel = 0; in_data = 64'h77; out_ready = 8'hFF;
    repeat (65535) @(posedge clk);
    #1;
    total++; if (accept_cnt !== 16'hFFFF) $display("FAIL wrap_max got=%h exp=ffff", accept_cnt); else pass_cnt++;
    tick();
    total++; if (accept_cnt !== 16'h0000) $display("FAIL wrap_zero got=%h exp=0000", accept_cnt); else pass_cnt++;
    @(negedge clk);
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_drain_refill();
    test_bcast();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
